// File: rtl/bash_hash_params_pkg.sv
// Shared constants and types for the BASH hash register map and its bus initiator.
// Addresses are byte addresses on the register bus.
package bash_hash_params_pkg;

  localparam int XLEN    = 32;
  localparam int ADDRLEN = 8;

  localparam logic [ADDRLEN-1:0] X_BASE          = 8'h00;
  localparam logic [ADDRLEN-1:0] Y_BASE          = 8'h80;
  localparam logic [ADDRLEN-1:0] L_ADDR          = 8'hC0;
  localparam logic [ADDRLEN-1:0] PREP_ADDR       = 8'hC4;
  localparam logic [ADDRLEN-1:0] START_ADDR      = 8'hC8;
  localparam logic [ADDRLEN-1:0] RDY_ACTIVE_ADDR = 8'hCC;

  localparam int X_WORDS         = 32;
  localparam int Y_WORDS         = 16;
  localparam int STAT_RDY_BIT    = 0;
  localparam int STAT_ACTIVE_BIT = XLEN / 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_L,
    ST_PREP,
    ST_LOAD_X,
    ST_START,
    ST_GAP,
    ST_POLL,
    ST_RD_Y,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/bash_hash_host.sv
// Bus initiator that sequences the BASH hash core: loads L and X, starts the core,
// polls status, then streams the 16 Y words out through a one-entry holding stage.
module bash_hash_host
  import bash_hash_params_pkg::*;
#(
  parameter int POLL_TIMEOUT = 4096
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_start_i,
  input  logic [XLEN-1:0]    cmd_len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  input  logic               msg_valid_i,
  output logic               msg_ready_o,
  input  logic [XLEN-1:0]    msg_data_i,
  output logic               y_valid_o,
  input  logic               y_ready_i,
  output logic [XLEN-1:0]    y_data_o,
  output logic               bus_en_o,
  output logic [3:0]         bus_we_o,
  output logic [ADDRLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0]    bus_wrdata_o,
  input  logic [XLEN-1:0]    bus_rddata_i,
  output state_t             state_o
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  // Streams: a word transfers on a cycle where valid and ready are both high;
  // a producer holds valid and data stable until that transfer happens.
  state_t          state_q, state_d;
  logic [XLEN-1:0] len_q;
  logic [4:0]      x_cnt_q;
  logic [3:0]      y_cnt_q;
  logic            y_issued_q;
  logic [PW-1:0]   poll_cnt_q;
  logic            err_q;
  logic            y_valid_q;
  logic [XLEN-1:0] y_data_q;

  logic status_ok, poll_last, x_last, y_issue;

  assign status_ok = bus_rddata_i[STAT_RDY_BIT] && !bus_rddata_i[STAT_ACTIVE_BIT];
  assign poll_last = (poll_cnt_q == PW'(POLL_TIMEOUT - 1));
  assign x_last    = (x_cnt_q == 5'(X_WORDS - 1));
  // Refill the holding stage when it is empty or being drained this cycle.
  assign y_issue   = (state_q == ST_RD_Y) && !y_issued_q && (!y_valid_q || y_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_start_i) state_d = ST_WR_L;
      ST_WR_L:   state_d = ST_PREP;
      ST_PREP:   state_d = ST_LOAD_X;
      ST_LOAD_X: if (msg_valid_i && x_last) state_d = ST_START;
      ST_START:  state_d = ST_GAP;
      ST_GAP:    state_d = ST_POLL;
      ST_POLL: begin
        if (status_ok)      state_d = ST_RD_Y;
        else if (poll_last) state_d = ST_IDLE;
      end
      ST_RD_Y:   if (y_issued_q && y_valid_q && y_ready_i) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_en_o     = 1'b0;
    bus_we_o     = 4'h0;
    bus_addr_o   = '0;
    bus_wrdata_o = '0;
    case (state_q)
      ST_WR_L: begin
        bus_en_o     = 1'b1;
        bus_we_o     = 4'hF;
        bus_addr_o   = L_ADDR;
        bus_wrdata_o = len_q;
      end
      ST_PREP: begin
        bus_en_o   = 1'b1;
        bus_we_o   = 4'hF;
        bus_addr_o = PREP_ADDR;
      end
      ST_LOAD_X: if (msg_valid_i) begin
        bus_en_o     = 1'b1;
        bus_we_o     = 4'hF;
        bus_addr_o   = X_BASE + {1'b0, x_cnt_q, 2'b00};
        bus_wrdata_o = msg_data_i;
      end
      ST_START: begin
        bus_en_o   = 1'b1;
        bus_we_o   = 4'hF;
        bus_addr_o = START_ADDR;
      end
      ST_POLL: begin
        bus_en_o   = 1'b1;
        bus_addr_o = RDY_ACTIVE_ADDR;
      end
      ST_RD_Y: if (y_issue) begin
        bus_en_o   = 1'b1;
        bus_addr_o = Y_BASE + {2'b00, y_cnt_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q      <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      y_issued_q <= 1'b0;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      y_valid_q  <= 1'b0;
      y_data_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && cmd_start_i) begin
        len_q <= cmd_len_i;
        err_q <= 1'b0;
      end
      if (state_q == ST_PREP) x_cnt_q <= '0;
      if (state_q == ST_LOAD_X && msg_valid_i && !x_last) x_cnt_q <= x_cnt_q + 5'd1;
      if (state_q == ST_GAP) poll_cnt_q <= '0;
      if (state_q == ST_POLL) begin
        if (status_ok) begin
          y_cnt_q    <= '0;
          y_issued_q <= 1'b0;
        end else if (poll_last) begin
          err_q <= 1'b1;
        end else begin
          poll_cnt_q <= poll_cnt_q + PW'(1);
        end
      end
      if (y_issue) begin
        y_data_q  <= bus_rddata_i;
        y_valid_q <= 1'b1;
        if (y_cnt_q == 4'(Y_WORDS - 1)) y_issued_q <= 1'b1;
        else                            y_cnt_q    <= y_cnt_q + 4'd1;
      end else if (y_ready_i) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_FINISH);
  assign msg_ready_o = (state_q == ST_LOAD_X);
  assign err_o       = err_q;
  assign y_valid_o   = y_valid_q;
  assign y_data_o    = y_data_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bash_hash_host.sv
// Directed bench for bash_hash_host: a register-bus responder, stream drivers,
// a bus access log compared against an expected queue, and one task per scenario.
module tb_bash_hash_host;
  import bash_hash_params_pkg::*;

  localparam int PT = 8;
  localparam int EW = 4 + ADDRLEN + XLEN;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_start_i = 1'b0;
  logic [XLEN-1:0]    cmd_len_i = '0;
  logic               busy_o, done_o, err_o;
  logic               msg_valid_i = 1'b0;
  logic               msg_ready_o;
  logic [XLEN-1:0]    msg_data_i = '0;
  logic               y_valid_o;
  logic               y_ready_i = 1'b1;
  logic [XLEN-1:0]    y_data_o;
  logic               bus_en_o;
  logic [3:0]         bus_we_o;
  logic [ADDRLEN-1:0] bus_addr_o;
  logic [XLEN-1:0]    bus_wrdata_o;
  logic [XLEN-1:0]    bus_rddata_i;
  state_t             dbg_state;

  bash_hash_host #(.POLL_TIMEOUT(PT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_start_i(cmd_start_i), .cmd_len_i(cmd_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .y_data_o(y_data_o),
    .bus_en_o(bus_en_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wrdata_o(bus_wrdata_o), .bus_rddata_i(bus_rddata_i),
    .state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  int gap_viol = 0;
  int bus_zero_viol = 0;
  int stat_cnt = 0;
  int rdy_after = 0;
  int msg_idx = 0;
  bit msg_gap = 1'b0;
  bit msg_hs_seen = 1'b0;
  bit y_toggle = 1'b0;
  bit stall_prev = 1'b0;
  logic [XLEN-1:0] stall_data = '0;

  logic [EW-1:0]   log_q[$];
  logic [EW-1:0]   exp_q[$];
  logic [XLEN-1:0] y_q[$];

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [XLEN-1:0] y_model(input int j);
    return 32'hB0A0_0000 + 32'(j) * 32'h0000_1111;
  endfunction

  function automatic logic [EW-1:0] ent_wr(input logic [ADDRLEN-1:0] a, input logic [XLEN-1:0] d);
    return {4'hF, a, d};
  endfunction

  function automatic logic [EW-1:0] ent_rd(input logic [ADDRLEN-1:0] a);
    return {4'h0, a, 32'h0};
  endfunction

  // register-bus responder: status turns ready after rdy_after not-ready reads
  always_comb begin
    bus_rddata_i = '0;
    if (bus_en_o && bus_we_o == 4'h0) begin
      if (bus_addr_o == RDY_ACTIVE_ADDR)
        bus_rddata_i = (stat_cnt >= rdy_after) ? 32'h0000_0001 : 32'h0001_0001;
      else if (bus_addr_o >= Y_BASE && bus_addr_o < Y_BASE + 8'd64)
        bus_rddata_i = y_model(int'((bus_addr_o - Y_BASE) >> 2));
    end
  end

  always @(posedge clk)
    if (rst_n && bus_en_o && bus_we_o == 4'h0 && bus_addr_o == RDY_ACTIVE_ADDR) stat_cnt++;

  // stream drivers, updated just after the active edge
  always @(posedge clk) begin
    #1;
    if (msg_hs_seen) begin
      msg_idx++;
      msg_hs_seen = 1'b0;
    end
    msg_valid_i = (msg_idx < 32) && (!msg_gap || (cyc % 3 == 0));
    msg_data_i  = 32'h1000 + 32'(msg_idx);
    y_ready_i   = y_toggle ? ~y_ready_i : 1'b1;
  end

  // monitor on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_en_o) log_q.push_back({bus_we_o, bus_addr_o, bus_wrdata_o});
      if (!bus_en_o && (bus_we_o != 4'h0 || bus_addr_o != '0 || bus_wrdata_o != '0)) bus_zero_viol++;
      if (bus_en_o && msg_ready_o && !msg_valid_i) gap_viol++;
      msg_hs_seen = msg_valid_i && msg_ready_o;
      if (y_valid_o && y_ready_i) y_q.push_back(y_data_o);
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_prev) begin
        checks++;
        if (y_valid_o !== 1'b1 || y_data_o !== stall_data) begin
          errors++;
          $display("FAIL y_stall_hold: valid=%0b data=%h, required valid=1 data=%h", y_valid_o, y_data_o, stall_data);
        end
      end
      stall_prev = y_valid_o && !y_ready_i;
      stall_data = y_data_o;
    end else begin
      msg_hs_seen = 1'b0;
      stall_prev  = 1'b0;
    end
  end

  task automatic clear_logs();
    log_q.delete();
    y_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    gap_viol = 0;
    stat_cnt = 0;
    msg_idx  = 0;
  endtask

  task automatic build_exp(input logic [XLEN-1:0] len, input int nstat, input int ny);
    exp_q.delete();
    exp_q.push_back(ent_wr(L_ADDR, len));
    exp_q.push_back(ent_wr(PREP_ADDR, 32'h0));
    for (int i = 0; i < X_WORDS; i++) exp_q.push_back(ent_wr(8'(4 * i), 32'h1000 + 32'(i)));
    exp_q.push_back(ent_wr(START_ADDR, 32'h0));
    for (int i = 0; i < nstat; i++) exp_q.push_back(ent_rd(RDY_ACTIVE_ADDR));
    for (int j = 0; j < ny; j++) exp_q.push_back(ent_rd(Y_BASE + 8'(4 * j)));
  endtask

  task automatic start_cmd(input logic [XLEN-1:0] len);
    @(posedge clk); #1;
    cmd_start_i = 1'b1;
    cmd_len_i   = len;
    start_cyc   = cyc;
    @(posedge clk); #1;
    cmd_start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_wait_idle: busy still 1 after 2000 cycles, required 0", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({busy_o, done_o, err_o, msg_ready_o, y_valid_o, bus_en_o, bus_we_o, bus_addr_o, bus_wrdata_o, y_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b en=%0b y_valid=%0b, required all 0",
               busy_o, done_o, err_o, bus_en_o, y_valid_o);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int n;
    clear_logs();
    rdy_after = 0;
    build_exp(32'h0000_0040, 1, 16);
    start_cmd(32'h0000_0040);
    for (n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (cyc == start_cyc + 55) break;
    end
    // a start request in the FINISH cycle must be dropped
    cmd_start_i = 1'b1;
    cmd_len_i   = 32'h5555_5555;
    @(posedge clk); #1;
    cmd_start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_busy_after_finish: got %0b, required 0", busy_o);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL finish_start_dropped: busy=%0b, required 0", busy_o);
    end
    checks++;
    if (done_cyc - start_cyc != 55) begin
      errors++;
      $display("FAIL latency_done_cycle: got %0d, required 55", done_cyc - start_cyc);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL latency_done_count: got %0d, required 1", done_cnt);
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL latency_bus_count: got %0d, required %0d", log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_nominal();
    clear_logs();
    rdy_after = 5;
    build_exp(32'h0000_0180, 6, 16);
    start_cmd(32'h0000_0180);
    wait_idle("nominal");
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL nominal_bus_count: got %0d, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL nominal_bus[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (y_q.size() != Y_WORDS) begin
      errors++;
      $display("FAIL nominal_y_count: got %0d, required %0d", y_q.size(), Y_WORDS);
    end
    for (int j = 0; j < y_q.size() && j < Y_WORDS; j++) begin
      checks++;
      if (y_q[j] !== y_model(j)) begin
        errors++;
        $display("FAIL nominal_y[%0d]: got %h, required %h", j, y_q[j], y_model(j));
      end
    end
    checks++;
    if (done_cnt != 1 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done_err: done=%0d err=%0b, required done=1 err=0", done_cnt, err_o);
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    rdy_after = 2;
    y_toggle  = 1'b1;
    start_cmd(32'h0000_0200);
    wait_idle("backpressure");
    y_toggle = 1'b0;
    checks++;
    if (y_q.size() != Y_WORDS) begin
      errors++;
      $display("FAIL backpressure_y_count: got %0d, required %0d", y_q.size(), Y_WORDS);
    end
    for (int j = 0; j < y_q.size() && j < Y_WORDS; j++) begin
      checks++;
      if (y_q[j] !== y_model(j)) begin
        errors++;
        $display("FAIL backpressure_y[%0d]: got %h, required %h", j, y_q[j], y_model(j));
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL backpressure_done: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_gapped_msg();
    clear_logs();
    rdy_after = 0;
    msg_gap   = 1'b1;
    build_exp(32'h0000_0100, 1, 16);
    start_cmd(32'h0000_0100);
    wait_idle("gapped");
    msg_gap = 1'b0;
    checks++;
    if (gap_viol != 0) begin
      errors++;
      $display("FAIL gapped_bus_in_gap: got %0d accesses, required 0", gap_viol);
    end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gapped_bus_count: got %0d, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gapped_bus[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    rdy_after = 1000;
    build_exp(32'h0000_0077, PT, 0);
    start_cmd(32'h0000_0077);
    wait_idle("timeout");
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_bus_count: got %0d, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_bus[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL timeout_flags: err=%0b busy=%0b done=%0d, required err=1 busy=0 done=0", err_o, busy_o, done_cnt);
    end
    clear_logs();
    rdy_after = 0;
    start_cmd(32'h0000_0078);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: got %0b, required 0", err_o);
    end
    wait_idle("timeout_retry");
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL timeout_retry_done: got %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    clear_logs();
    rdy_after = 0;
    start_cmd(32'h0000_0300);
    for (n = 0; n < 200; n++) begin
      @(posedge clk); #3;
      if (log_q.size() >= 12) break;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, msg_ready_o, y_valid_o, bus_en_o, bus_we_o, bus_addr_o, bus_wrdata_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%0b en=%0b ready=%0b addr=%h, required all 0",
               busy_o, bus_en_o, msg_ready_o, bus_addr_o);
    end
    checks++;
    if (done_cnt != 0 || log_q.size() != 12) begin
      errors++;
      $display("FAIL midreset_progress: done=%0d accesses=%0d, required done=0 accesses=12", done_cnt, log_q.size());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    build_exp(32'h0000_0301, 1, 16);
    start_cmd(32'h0000_0301);
    wait_idle("midreset_restart");
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_restart_count: got %0d, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midreset_restart_bus[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_in_poll();
    int n;
    clear_logs();
    rdy_after = 4;
    build_exp(32'h0000_0300, 5, 16);
    start_cmd(32'h0000_0300);
    for (n = 0; n < 200; n++) begin
      @(posedge clk); #3;
      if (log_q.size() >= 36) break;
    end
    @(posedge clk); #1;
    cmd_start_i = 1'b1;
    cmd_len_i   = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    cmd_start_i = 1'b0;
    wait_idle("poll_start");
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL poll_start_bus_count: got %0d, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL poll_start_bus[%0d]: got %h, required %h", i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL poll_start_done: got %0d, required 1", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_nominal();
    test_backpressure();
    test_gapped_msg();
    test_timeout();
    test_reset_mid_load();
    test_start_in_poll();
    checks++;
    if (bus_zero_viol != 0) begin
      errors++;
      $display("FAIL bus_idle_zero: got %0d nonzero idle cycles, required 0", bus_zero_viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
